// File: rtl/lock_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// lock_ctrl_fsm
//   Second-generation digital-lock control FSM. Consumes the code comparator
//   result and the user command strobes and drives unlock, code-change-ready
//   and code-register load-enable outputs. Counts consecutive wrong attempts
//   up to MAX_WRONG, then holds a timed LOCKOUT (auto-release after
//   LOCK_CYCLES, or permanent when LOCK_CYCLES=0). OPEN and READY fall back
//   to IDLE after OPEN_CYCLES idle cycles (disabled when OPEN_CYCLES=0).
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   asynchronous, active-low reset
//   compare     in   1 = entered code matches stored code (used only with a command)
//   enter       in   enter command strobe
//   change      in   change-code command strobe
//   unlocked    out  high in OPEN
//   ready       out  high in READY
//   load        out  one-cycle code-register load enable (LOAD state)
//   locked_out  out  high in LOCKOUT
//   wrong_cnt   out  consecutive wrong attempts, saturates at MAX_WRONG
//   state_code  out  IDLE=000 LOCKOUT=010 OPEN=100 READY=101 LOAD=110
// -----------------------------------------------------------------------------
module lock_ctrl_fsm #(
  parameter int unsigned MAX_WRONG   = 2,
  parameter int unsigned LOCK_CYCLES = 1000,
  parameter int unsigned OPEN_CYCLES = 500,
  parameter int unsigned TW          = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       compare,
  input  logic       enter,
  input  logic       change,
  output logic       unlocked,
  output logic       ready,
  output logic       load,
  output logic       locked_out,
  output logic [3:0] wrong_cnt,
  output logic [2:0] state_code
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_LOCKOUT = 3'b010,
    ST_OPEN    = 3'b100,
    ST_READY   = 3'b101,
    ST_LOAD    = 3'b110
  } state_t;

  localparam logic [3:0]    MAX_W      = 4'(MAX_WRONG);
  // Last timer value of a state lasting N cycles is N-1; unused when N=0.
  localparam logic [TW-1:0] OPEN_LAST  = TW'(OPEN_CYCLES - 32'd1);
  localparam logic [TW-1:0] LOCK_LAST  = TW'(LOCK_CYCLES - 32'd1);
  localparam bit            OPEN_TO_EN = (OPEN_CYCLES != 32'd0);
  localparam bit            LOCK_TO_EN = (LOCK_CYCLES != 32'd0);
  localparam logic [TW-1:0] TIMER_ZERO = TW'(0);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  state_t        state_q, state_d;
  logic [3:0]    wrong_cnt_q, wrong_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          unlocked_q, unlocked_d;
  logic          ready_q, ready_d;
  logic          load_q, load_d;
  logic          locked_out_q, locked_out_d;

  logic       cmd_e, cmd_c, cmd_any;
  logic [3:0] wrong_next;
  logic       wrong_lock;
  logic       open_to, lock_to;

  // Command decode, timeout detection and next-state / next-count logic.
  always_comb begin
    cmd_e      = enter & ~change;
    cmd_c      = change & ~enter;
    cmd_any    = cmd_e | cmd_c;
    wrong_next = wrong_cnt_q + 4'd1;
    // >= rather than == keeps the count from ever passing MAX_WRONG.
    wrong_lock = (wrong_next >= MAX_W);
    open_to    = OPEN_TO_EN && (timer_q == OPEN_LAST);
    lock_to    = LOCK_TO_EN && (timer_q == LOCK_LAST);

    state_d     = state_q;
    wrong_cnt_d = wrong_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_any && compare) begin
          state_d     = cmd_e ? ST_OPEN : ST_READY;
          wrong_cnt_d = 4'd0;
        end else if (cmd_any) begin
          state_d     = wrong_lock ? ST_LOCKOUT : ST_IDLE;
          wrong_cnt_d = wrong_lock ? MAX_W : wrong_next;
        end else begin
          state_d     = ST_IDLE;
          wrong_cnt_d = wrong_cnt_q;
        end
      end
      ST_OPEN: begin
        // A valid command takes priority over the idle timeout.
        if (cmd_any && compare) begin
          state_d     = cmd_e ? ST_IDLE : ST_READY;
          wrong_cnt_d = 4'd0;
        end else if (cmd_any) begin
          state_d     = wrong_lock ? ST_LOCKOUT : ST_IDLE;
          wrong_cnt_d = wrong_lock ? MAX_W : wrong_next;
        end else if (open_to) begin
          state_d     = ST_IDLE;
          wrong_cnt_d = wrong_cnt_q;
        end else begin
          state_d     = ST_OPEN;
          wrong_cnt_d = wrong_cnt_q;
        end
      end
      ST_READY: begin
        // Any command (compare ignored) commits the new code.
        if (cmd_any) begin
          state_d = ST_LOAD;
        end else if (open_to) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_READY;
        end
        wrong_cnt_d = 4'd0;
      end
      ST_LOAD: begin
        state_d     = ST_IDLE;
        wrong_cnt_d = 4'd0;
      end
      ST_LOCKOUT: begin
        if (lock_to) begin
          state_d     = ST_IDLE;
          wrong_cnt_d = 4'd0;
        end else begin
          state_d     = ST_LOCKOUT;
          wrong_cnt_d = wrong_cnt_q;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        wrong_cnt_d = 4'd0;
      end
    endcase

    // Timer restarts on every state change and only runs in timed states.
    if (state_d != state_q) begin
      timer_d = TIMER_ZERO;
    end else if ((state_q == ST_OPEN) || (state_q == ST_READY) ||
                 (state_q == ST_LOCKOUT)) begin
      timer_d = timer_q + TIMER_ONE;
    end else begin
      timer_d = TIMER_ZERO;
    end

    // Outputs are decoded from the next state so the registered copies
    // line up with state_q.
    unlocked_d   = (state_d == ST_OPEN);
    ready_d      = (state_d == ST_READY);
    load_d       = (state_d == ST_LOAD);
    locked_out_d = (state_d == ST_LOCKOUT);
  end

  // State, attempt counter, timer and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      wrong_cnt_q  <= 4'd0;
      timer_q      <= TIMER_ZERO;
      unlocked_q   <= 1'b0;
      ready_q      <= 1'b0;
      load_q       <= 1'b0;
      locked_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wrong_cnt_q  <= wrong_cnt_d;
      timer_q      <= timer_d;
      unlocked_q   <= unlocked_d;
      ready_q      <= ready_d;
      load_q       <= load_d;
      locked_out_q <= locked_out_d;
    end
  end

  assign unlocked   = unlocked_q;
  assign ready      = ready_q;
  assign load       = load_q;
  assign locked_out = locked_out_q;
  assign wrong_cnt  = wrong_cnt_q;
  assign state_code = state_q;

endmodule

// File: tb/tb_lock_ctrl_fsm.sv
// Directed testbench for lock_ctrl_fsm (MAX_WRONG=3, LOCK_CYCLES=8, OPEN_CYCLES=5).
module tb_lock_ctrl_fsm;

  logic       clock;
  logic       reset;
  logic       compare;
  logic       enter;
  logic       change;
  logic       unlocked;
  logic       ready;
  logic       load;
  logic       locked_out;
  logic [3:0] wrong_cnt;
  logic [2:0] state_code;

  int pass_cnt  = 0;
  int total_cnt = 0;

  lock_ctrl_fsm #(
    .MAX_WRONG  (3),
    .LOCK_CYCLES(8),
    .OPEN_CYCLES(5),
    .TW         (16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .compare   (compare),
    .enter     (enter),
    .change    (change),
    .unlocked  (unlocked),
    .ready     (ready),
    .load      (load),
    .locked_out(locked_out),
    .wrong_cnt (wrong_cnt),
    .state_code(state_code)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Full output snapshot against expected values.
  task automatic check_all(input string tag, input logic [2:0] st, input logic [3:0] wc,
                           input logic ul, input logic rd, input logic ld, input logic lo);
    check({tag, ".state"},      {1'b0, state_code}, {1'b0, st});
    check({tag, ".wrong_cnt"},  wrong_cnt, wc);
    check({tag, ".unlocked"},   {3'b000, unlocked},   {3'b000, ul});
    check({tag, ".ready"},      {3'b000, ready},      {3'b000, rd});
    check({tag, ".load"},       {3'b000, load},       {3'b000, ld});
    check({tag, ".locked_out"}, {3'b000, locked_out}, {3'b000, lo});
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One-cycle command pulse, then inputs return to idle.
  task automatic pulse(input logic e, input logic c, input logic cmp);
    enter   = e;
    change  = c;
    compare = cmp;
    tick();
    enter   = 1'b0;
    change  = 1'b0;
    compare = 1'b0;
  endtask

  initial begin
    reset   = 1'b0;
    enter   = 1'b0;
    change  = 1'b0;
    compare = 1'b0;
    tick();
    tick();
    check_all("reset_hold", 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    check_all("reset_rel", 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 1: open, then idle timeout after exactly 5 cycles in OPEN
    pulse(1'b1, 1'b0, 1'b1);
    check_all("t1_open", 3'b100, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) tick();
    check_all("t1_open_c5", 3'b100, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_all("t1_timeout", 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 2: wrong attempts into lockout, ignored command, auto-release after 8
    pulse(1'b1, 1'b0, 1'b0);
    check_all("t2_wrong1", 3'b000, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    check_all("t2_wrong2", 3'b000, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    check_all("t2_lockout", 3'b010, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b1);
    check_all("t2_ignored", 3'b010, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (6) tick();
    check_all("t2_lock_c8", 3'b010, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check_all("t2_release", 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 3: change code -> READY -> LOAD for one cycle -> IDLE
    pulse(1'b0, 1'b1, 1'b1);
    check_all("t3_ready", 3'b101, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    check_all("t3_load", 3'b110, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check_all("t3_idle", 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 4: count cleared by correct entry, wrong change in OPEN relocks
    pulse(1'b1, 1'b0, 1'b0);
    check_all("t4_wrong1", 3'b000, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b1);
    check_all("t4_open", 3'b100, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    check_all("t4_relock", 3'b000, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b1);
    check_all("t4_open2", 3'b100, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b1);
    check_all("t4_close", 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 5: command on the READY timeout cycle wins; enter&change is no command
    pulse(1'b0, 1'b1, 1'b1);
    check_all("t5_ready", 3'b101, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    check_all("t5_ready_c4", 3'b101, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    check_all("t5_load", 3'b110, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check_all("t5_idle", 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    check_all("t5_wrong1", 3'b000, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b1, 1'b0);
    check_all("t5_both_wrong", 3'b000, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b1, 1'b1);
    check_all("t5_both_match", 3'b000, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);

    // READY idle timeout without a command returns to IDLE, no load
    pulse(1'b0, 1'b1, 1'b1);
    check_all("t5b_ready", 3'b101, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (5) tick();
    check_all("t5b_timeout", 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 6: asynchronous reset in the third lockout cycle
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    check_all("t6_wrong2", 3'b000, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    check_all("t6_lockout", 3'b010, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    check_all("t6_async_rst", 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    check_all("t6_after_rel", 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/lock_ctrl_fsm.md
Name: lock_ctrl_fsm

Overview:
- Parametrised digital-lock control FSM; the second-generation lock controller.
- Consumes the code comparator result (compare) and the user command strobes (enter, change).
- Drives the unlock, code-change-ready and code-register load-enable outputs.
- Adds over the first generation: configurable wrong-attempt limit, timed lockout with auto-release, and auto-relock/abort timeout in OPEN and READY.

Parameters:
MAX_WRONG, 2, consecutive wrong attempts that trigger LOCKOUT; legal range 1..15.
LOCK_CYCLES, 1000, cycles spent in LOCKOUT before auto-release; 0 = permanent until reset.
OPEN_CYCLES, 500, cycles OPEN/READY may idle before returning to IDLE; 0 = no timeout.
TW, 16, timer width; LOCK_CYCLES and OPEN_CYCLES must be < 2^TW.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
compare  input  1  1 = entered code matches stored code; sampled only with a valid command
enter  input  1  enter command strobe
change  input  1  change-code command strobe
unlocked  output  1  high in OPEN
ready  output  1  high in READY (new code may be keyed)
load  output  1  one-cycle code-register load enable, high in LOAD
locked_out  output  1  high in LOCKOUT
wrong_cnt  output  4  consecutive wrong attempts, saturates at MAX_WRONG
state_code  output  3  IDLE=000, LOCKOUT=010, OPEN=100, READY=101, LOAD=110

Behaviour:
- Reset (reset=0, async): state IDLE, wrong_cnt 0, timer 0. All outputs 0 except state_code=000. Reset mid-lockout or mid-load aborts immediately.
- All outputs are Moore-decoded from registered state and wrong_cnt; no combinational path from inputs to outputs.
- Command decode: E = enter & ~change; C = change & ~enter. enter=change=1 or both 0 = no command. Strobes are level-sampled each cycle; the driver supplies one-cycle pulses.
- Wrong attempt = (E|C) & ~compare. Next count n = wrong_cnt+1.
- IDLE:
  - E&compare -> OPEN, wrong_cnt<=0.
  - C&compare -> READY, wrong_cnt<=0.
  - Wrong attempt with n==MAX_WRONG -> LOCKOUT, wrong_cnt<=MAX_WRONG.
  - Other wrong attempt -> stay IDLE, wrong_cnt<=n.
- OPEN:
  - E&compare -> IDLE (relock).
  - C&compare -> READY.
  - Wrong attempt -> same counting as IDLE, but the non-lockout destination is IDLE (door relocks).
  - No command and timeout -> IDLE.
- READY:
  - E or C (compare ignored) -> LOAD.
  - No command and timeout -> IDLE, no load.
- LOAD: exactly one cycle, then IDLE. wrong_cnt held at 0.
- LOCKOUT: all commands ignored. After LOCK_CYCLES cycles -> IDLE, wrong_cnt<=0. LOCK_CYCLES=0: stays until reset.
- Timer:
  - Cleared on every state change.
  - Increments each cycle in OPEN, READY and LOCKOUT; holds 0 elsewhere.
  - Timeout fires when timer == N-1, where N = OPEN_CYCLES or LOCK_CYCLES, so the state lasts exactly N cycles.
  - N=0 disables timeout.
- Priority: a valid command in the same cycle as a timeout wins over the timeout.
- MAX_WRONG=1: first wrong attempt from IDLE/OPEN enters LOCKOUT directly.
- wrong_cnt never exceeds MAX_WRONG and never wraps.
- Illegal state encodings recover to IDLE on the next clock.

Test Plan:
All scenarios use MAX_WRONG=3, LOCK_CYCLES=8, OPEN_CYCLES=5.
1. Reset, then E pulse with compare=1 -> next cycle state_code=100, unlocked=1. After 5 idle cycles in OPEN -> state_code=000, unlocked=0.
2. Two wrong E pulses -> wrong_cnt 1 then 2, stays IDLE. Third wrong C pulse -> locked_out=1, wrong_cnt=3. E with compare=1 during lockout -> ignored. Exactly 8 cycles later -> IDLE, wrong_cnt=0.
3. C pulse with compare=1 -> READY (101). E pulse -> LOAD: load=1 for exactly one cycle, then IDLE, wrong_cnt=0.
4. Wrong E -> wrong_cnt=1. Then correct E -> OPEN with wrong_cnt=0. Then wrong C in OPEN -> IDLE, wrong_cnt=1.
5. In READY, command arrives on the 5th cycle (timeout cycle) -> LOAD, not IDLE. enter=change=1 in IDLE -> no state or count change.
6. Assert reset=0 asynchronously mid-LOCKOUT (cycle 3) -> outputs clear immediately. After release, state IDLE, wrong_cnt=0.
